// File: rtl/hud_pkg.sv
// rtl/hud_pkg.sv - shared constants and types for the HUD portrait sequencer
package hud_pkg;

  localparam int SPR_W_DEF        = 64;
  localparam int SPR_H_DEF        = 64;
  localparam int ADDR_W_DEF       = 12;
  localparam int BLINK_FRAMES_DEF = 8;

  localparam logic [9:0] P1_X0 = 10'd16;
  localparam logic [9:0] P1_Y0 = 10'd16;
  localparam logic [9:0] P2_X0 = 10'd560;
  localparam logic [9:0] P2_Y0 = 10'd16;

  localparam logic [2:0] TRANSPARENT_IDX = 3'd0;
  localparam logic [2:0] BORDER_IDX      = 3'd7;

  typedef enum logic {
    P1 = 1'b0,
    P2 = 1'b1
  } portrait_sel_t;

  typedef struct packed {
    logic          valid;
    portrait_sel_t sel;
    logic          hidden;
  } pipe_sb_t;

endpackage

// File: rtl/hud_blink_timer.sv
// rtl/hud_blink_timer.sv - per-portrait hit-blink frame counter
module hud_blink_timer #(
  parameter int BLINK_FRAMES = 8
) (
  input  logic vga_clk,
  input  logic reset,
  input  logic hit,
  input  logic frame_start,
  input  logic parity,
  output logic hidden
);

  localparam int CNT_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [CNT_W-1:0] LP_LOAD = CNT_W'(BLINK_FRAMES);

  logic [CNT_W-1:0] r_cnt;

  // A hit on the same cycle as frame_start restarts the full blink.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (hit) begin
      r_cnt <= LP_LOAD;
    end else if (frame_start && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign hidden = (r_cnt != '0) & parity;

endmodule

// File: rtl/hud_portrait_ctrl.sv
// rtl/hud_portrait_ctrl.sv - two-portrait sequencer for a shared sprite ROM
// Optional border overlay enabled by defining HUD_BORDER_EN.
module hud_portrait_ctrl
  import hud_pkg::*;
#(
  parameter int SPR_W        = SPR_W_DEF,
  parameter int SPR_H        = SPR_H_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int BLINK_FRAMES = BLINK_FRAMES_DEF
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [9:0]        drawX,
  input  logic [9:0]        drawY,
  input  logic              blank,
  input  logic              frame_start,
  input  logic              pos_we,
  input  logic              pos_sel,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic              p1_hit,
  input  logic              p2_hit,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [2:0]        rom_q,
  output logic [2:0]        pix_index,
  output logic              pix_on
);

  localparam int CW = $clog2(SPR_W);
  localparam logic [9:0] LP_W = 10'(SPR_W);
  localparam logic [9:0] LP_H = 10'(SPR_H);

  logic [9:0]    r_act_x [2];
  logic [9:0]    r_act_y [2];
  logic [9:0]    r_sh_x  [2];
  logic [9:0]    r_sh_y  [2];
  logic          r_parity;
  pipe_sb_t      r_sb;
  logic [9:0]    w_dx [2];
  logic [9:0]    w_dy [2];
  logic [1:0]    w_in;
  logic [1:0]    w_hidden;
  portrait_sel_t w_sel;
  logic [9:0]    w_dx_sel;
  logic [9:0]    w_dy_sel;
  logic [9:0]    w_col;
  logic [2:0]    w_idx;
  logic          w_opaque;

  // Write-through: a shadow write on the commit cycle lands in the active copy too.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_act_x[0] <= P1_X0;  r_act_y[0] <= P1_Y0;
      r_act_x[1] <= P2_X0;  r_act_y[1] <= P2_Y0;
      r_sh_x[0]  <= P1_X0;  r_sh_y[0]  <= P1_Y0;
      r_sh_x[1]  <= P2_X0;  r_sh_y[1]  <= P2_Y0;
      r_parity   <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (pos_we && (pos_sel == 1'(i))) begin
          r_sh_x[i] <= pos_x;
          r_sh_y[i] <= pos_y;
        end
        if (frame_start) begin
          r_act_x[i] <= (pos_we && (pos_sel == 1'(i))) ? pos_x : r_sh_x[i];
          r_act_y[i] <= (pos_we && (pos_sel == 1'(i))) ? pos_y : r_sh_y[i];
        end
      end
      if (frame_start) r_parity <= ~r_parity;
    end
  end

  hud_blink_timer #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink_p1 (
    .vga_clk(vga_clk), .reset(reset), .hit(p1_hit), .frame_start(frame_start),
    .parity(r_parity), .hidden(w_hidden[0])
  );

  hud_blink_timer #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink_p2 (
    .vga_clk(vga_clk), .reset(reset), .hit(p2_hit), .frame_start(frame_start),
    .parity(r_parity), .hidden(w_hidden[1])
  );

  // Unsigned differences let an origin near the screen edge wrap cleanly.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_dx[i] = drawX - r_act_x[i];
      w_dy[i] = drawY - r_act_y[i];
      w_in[i] = (w_dx[i] < LP_W) && (w_dy[i] < LP_H);
    end
  end

  assign w_sel    = w_in[0] ? P1 : P2;
  assign w_dx_sel = (w_sel == P1) ? w_dx[0] : w_dx[1];
  assign w_dy_sel = (w_sel == P1) ? w_dy[0] : w_dy[1];
  assign w_col    = (w_sel == P2) ? (LP_W - 10'd1 - w_dx_sel) : w_dx_sel;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      rom_address <= '0;
      r_sb        <= '{valid: 1'b0, sel: P1, hidden: 1'b0};
    end else begin
      if (|w_in) rom_address <= ADDR_W'({w_dy_sel, CW'(w_col)});
      r_sb <= '{valid:  blank & (|w_in),
                sel:    w_sel,
                hidden: (w_sel == P1) ? w_hidden[0] : w_hidden[1]};
    end
  end

`ifdef HUD_BORDER_EN
  logic r_border;
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_border <= 1'b0;
    end else begin
      r_border <= (|w_in) && ((w_dy_sel == 10'd0) || (w_dy_sel == LP_H - 10'd1) ||
                              (w_col == 10'd0) || (w_col == LP_W - 10'd1));
    end
  end
  assign w_idx    = r_border ? BORDER_IDX : rom_q;
  assign w_opaque = r_border | (rom_q != TRANSPARENT_IDX);
`else
  assign w_idx    = rom_q;
  assign w_opaque = (rom_q != TRANSPARENT_IDX);
`endif

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      pix_index <= '0;
      pix_on    <= 1'b0;
    end else begin
      pix_index <= w_idx;
      pix_on    <= r_sb.valid & ~r_sb.hidden & w_opaque & (r_sb.sel == P1 || r_sb.sel == P2);
    end
  end

endmodule

// File: tb/tb_hud_portrait_ctrl.sv
// tb/tb_hud_portrait_ctrl.sv - randomized self-checking bench for hud_portrait_ctrl
module tb_hud_portrait_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  drawX, drawY;
  logic        blank, frame_start, pos_we, pos_sel, p1_hit, p2_hit;
  logic [9:0]  pos_x, pos_y;
  logic [11:0] rom_address;
  logic [2:0]  rom_q;
  logic [2:0]  pix_index;
  logic        pix_on;

  hud_portrait_ctrl dut (
    .vga_clk(clk), .reset(reset), .drawX(drawX), .drawY(drawY), .blank(blank),
    .frame_start(frame_start), .pos_we(pos_we), .pos_sel(pos_sel),
    .pos_x(pos_x), .pos_y(pos_y), .p1_hit(p1_hit), .p2_hit(p2_hit),
    .rom_address(rom_address), .rom_q(rom_q), .pix_index(pix_index), .pix_on(pix_on)
  );

  always #5 clk = ~clk;

  int unsigned mem [4096];
  always @(negedge clk) rom_q = 3'(mem[rom_address]);

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference model: screen-space rules on plain integers.
  int ax [2], ay [2], sx [2], sy [2], cnt [2];
  bit par;
  int m_addr, m_pix;
  bit m_on, s1v, s1h, s1b;

  function automatic bit in_win(input int p);
    return (((int'(drawX) - ax[p]) & 1023) < 64) && (((int'(drawY) - ay[p]) & 1023) < 64);
  endfunction

  task automatic model_reset();
    ax[0] = 16;  ay[0] = 16;  ax[1] = 560; ay[1] = 16;
    sx = ax;     sy = ay;
    cnt[0] = 0;  cnt[1] = 0;  par = 0;
    m_addr = 0;  m_pix = 0;   m_on = 0;
    s1v = 0;     s1h = 0;     s1b = 0;
  endtask

  task automatic model_edge();
    int p, row, col, rq;
    bit any, nb;
    if (reset) begin
      model_reset();
      return;
    end
    rq = int'(mem[m_addr]);
`ifdef HUD_BORDER_EN
    m_pix = s1b ? 7 : rq;
    m_on  = s1v && !s1h && (s1b || rq != 0);
`else
    m_pix = rq;
    m_on  = s1v && !s1h && (rq != 0);
`endif
    any = in_win(0) || in_win(1);
    p   = in_win(0) ? 0 : 1;
    col = (int'(drawX) - ax[p]) & 1023;
    if (p == 1) col = 63 - col;
    row = (int'(drawY) - ay[p]) & 1023;
    nb  = any && (row == 0 || row == 63 || col == 0 || col == 63);
    if (any) m_addr = (row * 64 + col) % 4096;
    s1v = blank && any;
    s1h = (cnt[p] != 0) && par;
    s1b = nb;
    if (pos_we) begin
      sx[pos_sel] = int'(pos_x);
      sy[pos_sel] = int'(pos_y);
    end
    if (frame_start) begin
      ax = sx;  ay = sy;
      par = !par;
    end
    for (int i = 0; i < 2; i++) begin
      if ((i == 0 && p1_hit) || (i == 1 && p2_hit)) cnt[i] = 8;
      else if (frame_start && cnt[i] != 0) cnt[i] = cnt[i] - 1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("rom_address", int'(rom_address), m_addr);
    check("pix_index", int'(pix_index), m_pix);
    check("pix_on", int'(pix_on), int'(m_on));
  endtask

  task automatic idle();
    blank = 1; frame_start = 0; pos_we = 0; pos_sel = 0;
    pos_x = 0; pos_y = 0; p1_hit = 0; p2_hit = 0; reset = 0;
  endtask

  task automatic rand_inputs();
    int mode, org;
    idle();
    mode = int'($urandom_range(0, 2));
    org  = (mode == 2) ? 0 : mode;
    if (mode == 2) begin
      drawX = 10'($urandom_range(0, 799));
      drawY = 10'($urandom_range(0, 524));
    end else begin
      drawX = 10'(ax[org] + int'($urandom_range(0, 70)) - 3);
      drawY = 10'(ay[org] + int'($urandom_range(0, 70)) - 3);
    end
    blank       = ($urandom_range(0, 9) != 0);
    frame_start = ($urandom_range(0, 39) == 0);
    p1_hit      = ($urandom_range(0, 149) == 0);
    p2_hit      = ($urandom_range(0, 149) == 0);
    pos_we      = ($urandom_range(0, 79) == 0);
    pos_sel     = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 1) == 0) begin
      pos_x = 10'($urandom_range(0, 1023));
      pos_y = 10'($urandom_range(0, 1023));
    end else begin
      pos_x = 10'($urandom_range(0, 40) + (pos_sel ? 540 : 0));
      pos_y = 10'($urandom_range(0, 40));
    end
    reset = ($urandom_range(0, 799) == 0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = $urandom_range(0, 7);
    mem[132] = 5;
    idle();
    drawX = 0; drawY = 0;
    reset = 1;
    repeat (3) step();
    check("reset_rom_address", int'(rom_address), 0);
    check("reset_pix_on", int'(pix_on), 0);
    reset = 0;

    drawX = 20;  drawY = 18;  step();
    check("p1_addr_132", int'(rom_address), 132);
    drawX = 300; drawY = 300; step();
    check("p1_pix_index_5", int'(pix_index), 5);
    check("p1_pix_on", int'(pix_on), 1);
    drawX = 560; drawY = 16;  step();
    check("p2_mirror_63", int'(rom_address), 63);
    drawX = 561; step();
    check("p2_mirror_62", int'(rom_address), 62);

    pos_we = 1; pos_sel = 0; pos_x = 100; pos_y = 50;
    drawX = 20; drawY = 18; step();
    pos_we = 0; step();
    check("shadow_not_live", int'(rom_address), 132);
    frame_start = 1; step();
    frame_start = 0;
    drawX = 110; drawY = 50; step();
    check("shadow_committed", int'(rom_address), 10);

    pos_we = 1; pos_sel = 0; pos_x = 200; pos_y = 60; frame_start = 1;
    drawX = 0; drawY = 0; step();
    idle();
    drawX = 201; drawY = 61; step();
    check("write_through", int'(rom_address), 65);

    p1_hit = 1; frame_start = 1; step();
    idle();
    for (int f = 0; f < 10; f++) begin
      for (int k = 0; k < 4; k++) begin
        drawX = 10'(210 + k); drawY = 70; step();
      end
      frame_start = 1; step(); frame_start = 0;
    end

    for (int n = 0; n < 4000; n++) begin
      rand_inputs();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hud_portrait_ctrl.md
Name: hud_portrait_ctrl

Overview:
- Sequences one shared 64x64, 3-bit-index portrait sprite ROM for two HUD portraits (P1 left, P2 right, P2 horizontally mirrored).
- Per pixel: selects the owning portrait, computes the ROM address, re-aligns the ROM data with its sideband, and applies hit-blink and transparency.
- Sits between the VGA scan counters and the shared sprite ROM/palette; the palette lookup and the final pixel mux are external.

Parameters:
- SPR_W, 64, sprite width in pixels (power of 2).
- SPR_H, 64, sprite height in pixels.
- ADDR_W, 12, ROM address width; must satisfy 2**ADDR_W >= SPR_W*SPR_H.
- BLINK_FRAMES, 8, number of frames a portrait blinks after a hit pulse.

Ports:
- vga_clk  in  1  pixel clock; all state updates on the posedge.
- reset  in  1  synchronous, active-high.
- drawX  in  10  current scan column.
- drawY  in  10  current scan row.
- blank  in  1  1 = active video.
- frame_start  in  1  one-cycle pulse at the first cycle of vertical blank.
- pos_we  in  1  write strobe for the shadow position registers.
- pos_sel  in  1  0 = P1, 1 = P2.
- pos_x  in  10  shadow X origin.
- pos_y  in  10  shadow Y origin.
- p1_hit  in  1  one-cycle pulse: start P1 blink.
- p2_hit  in  1  one-cycle pulse: start P2 blink.
- rom_address  out  ADDR_W  to shared ROM (ROM samples on the negedge).
- rom_q  in  3  ROM palette index.
- pix_index  out  3  palette index for the palette lookup.
- pix_on  out  1  1 = portrait pixel opaque and visible.

Behaviour:
- Reset values:
  - rom_address = 0, pix_index = 0, pix_on = 0.
  - Active and shadow positions: P1 = (16,16), P2 = (560,16).
  - Both blink counters = 0, frame parity = 0, pipeline valid bits = 0.
- Reset mid-frame clears everything above; outputs are 0 on the cycle after reset is sampled.
- Position double-buffer:
  - pos_we writes the shadow register selected by pos_sel.
  - frame_start copies both shadows to the active registers.
  - pos_we coincident with frame_start: the new value is written to the shadow and is also committed this frame (write-through).
- Window test (active positions): in_Pn = (drawX - Xn) < SPR_W and (drawY - Yn) < SPR_H, as unsigned 10-bit differences, so origins wrap safely.
- Overlap: P1 has priority.
- Address computation:
  - col = drawX - Xsel; for P2, col = SPR_W-1-col.
  - row = drawY - Ysel.
  - rom_address = row*SPR_W + col, truncated to ADDR_W.
  - Outside both windows, rom_address holds its last value.
- Pipeline:
  - Edge N: sample drawX/drawY, register rom_address and sideband stage 1 (blank, hit_any, sel, hidden).
  - Negedge: ROM read.
  - Edge N+1: register pix_index = rom_q and pix_on = stage1.valid & (rom_q != 0).
  - Total latency is 2 posedges from drawX/drawY to pix_*.
- Blink:
  - p1_hit/p2_hit loads the matching counter with BLINK_FRAMES.
  - frame_start decrements each nonzero counter and toggles frame parity.
  - A hit coincident with frame_start: load wins (counter = BLINK_FRAMES).
  - A portrait is hidden when its counter != 0 and parity = 1.
  - A hidden P1 does NOT reveal P2 underneath; priority is decided before hiding.
- blank = 0: pix_on = 0 at the matching output cycle; pix_index still updates.

Optional Feature:
- Macro: HUD_BORDER_EN.
- Defined: a pixel with row or col equal to 0 or to the max forces pix_index = 7 and pix_on = 1 when visible, regardless of rom_q. The ROM is still addressed.
- Undefined: no border logic; pure sprite output.

Decomposition:
- Package hud_pkg holds:
  - the SPR_W/SPR_H/ADDR_W defaults;
  - the reset origin constants P1_X0/P1_Y0/P2_X0/P2_Y0;
  - TRANSPARENT_IDX = 0 and BORDER_IDX = 7;
  - typedef portrait_sel_t (P1, P2);
  - typedef struct pipe_sb_t {valid, sel, hidden}.
- One sub-module, hud_blink_timer: counter load/decrement plus the hidden output. It is instantiated twice and shares the parity bit.

Test Plan:
- Addressing and latency: P1 at (16,16), drawX=20, drawY=18 -> rom_address = 2*64+4 = 132 after edge 1. rom_q = 5 -> pix_index = 5, pix_on = 1 after edge 2.
- Mirror: P2 at (560,16), drawX=560, drawY=16 -> rom_address = 63. Next cycle drawX=561 -> 62.
- Transparency and blank: rom_q = 0 -> pix_on = 0. rom_q = 3 with blank = 0 -> pix_on = 0.
- Double buffer: pos_we P1 = (100,50) mid-frame -> addressing still uses (16,16) until frame_start, then (100,50). pos_we coincident with frame_start -> effective immediately.
- Blink: p1_hit -> P1 pix_on = 0 on odd-parity frames for 8 frame_starts, then steady. p1_hit coincident with frame_start -> counter = 8. Overlap with P2 in a hidden frame -> pix_on = 0.
- Reset mid-frame during an active blink -> pix_on = 0 next cycle, counter = 0, positions back to defaults.
